// File: rtl/irrigacao_pkg.sv
// Shared types and defaults for the irrigation controller slice.
package irrigacao_pkg;

    localparam int unsigned LARGURA_PADRAO = 11;

    typedef enum logic [2:0] {
        OCIOSO   = 3'd0,
        CARREGA  = 3'd1,
        IRRIGA   = 3'd2,
        DESCANSO = 3'd3,
        ALARME   = 3'd4,
        PAUSA    = 3'd5
    } estado_t;

    typedef enum logic [1:0] {
        NENHUM = 2'd0,
        ASP    = 2'd1,
        GOT    = 2'd2
    } modo_t;

endpackage

// File: rtl/contador_regressivo.sv
// Loadable seconds down-counter with clear, tick-driven decrement that saturates at zero,
// and zero/one flags for phase-end detection.
module contador_regressivo
    import irrigacao_pkg::*;
#(
    parameter int unsigned LARGURA = LARGURA_PADRAO
) (
    input  logic               i_clock,
    input  logic               i_resetN,
    input  logic               i_limpar,
    input  logic               i_carregar,
    input  logic [LARGURA-1:0] i_valor,
    input  logic               i_tick,
    output logic [LARGURA-1:0] o_valor,
    output logic               o_zero,
    output logic               o_um
);

    logic [LARGURA-1:0] r_valor;

    always_ff @(posedge i_clock or negedge i_resetN) begin
        if (!i_resetN) begin
            r_valor <= '0;
        end else if (i_limpar) begin
            r_valor <= '0;
        end else if (i_carregar) begin
            r_valor <= i_valor;
        end else if (i_tick && (r_valor != '0)) begin
            r_valor <= r_valor - 1'b1;
        end
    end

    assign o_valor = r_valor;
    assign o_zero  = (r_valor == '0);
    assign o_um    = (r_valor == {{(LARGURA-1){1'b0}}, 1'b1});

endmodule

// File: rtl/controlador_irrigacao.sv
// Irrigation-cycle scheduler: request arbitration, countdown control, valve decode, low-water lockout.
// Optional hold feature enabled by defining PAUSA_EN (adds the pausa port and state PAUSA).
module controlador_irrigacao
    import irrigacao_pkg::*;
#(
    parameter int unsigned TEMPO_ASPERSAO_S    = 360,
    parameter int unsigned TEMPO_GOTEJAMENTO_S = 720,
    parameter int unsigned DESCANSO_S          = 60,
    parameter int unsigned NIVEL_MINIMO        = 1,
    parameter int unsigned LARGURA             = LARGURA_PADRAO
) (
    input  logic               clock,
    input  logic               resetN,
    input  logic               umSegundo,
    input  logic               aspersao,
    input  logic               gotejamento,
    input  logic [2:0]         nivelDagua,
`ifdef PAUSA_EN
    input  logic               pausa,
`endif
    output logic               valvulaAspersao,
    output logic               valvulaGotejamento,
    output logic               carregar,
    output logic               habilitar,
    output logic [LARGURA-1:0] restante,
    output logic [2:0]         estado,
    output logic               alarme,
    output logic               fim
);

    localparam longint unsigned TEMPO_MAX = (64'd1 << LARGURA) - 64'd1;

    if (TEMPO_ASPERSAO_S < 1 || TEMPO_ASPERSAO_S > TEMPO_MAX ||
        TEMPO_GOTEJAMENTO_S < 1 || TEMPO_GOTEJAMENTO_S > TEMPO_MAX ||
        DESCANSO_S < 1 || DESCANSO_S > TEMPO_MAX) begin : g_tempo_invalido
        $error("controlador_irrigacao: times must lie in 1..2^LARGURA-1");
    end

    localparam logic [LARGURA-1:0] T_ASP  = LARGURA'(TEMPO_ASPERSAO_S);
    localparam logic [LARGURA-1:0] T_GOT  = LARGURA'(TEMPO_GOTEJAMENTO_S);
    localparam logic [LARGURA-1:0] T_DESC = LARGURA'(DESCANSO_S);
    localparam logic [3:0]         N_MIN  = 4'(NIVEL_MINIMO);

    estado_t            r_estado, w_prox;
    modo_t              r_modo, w_modo_prox;
    logic               r_valvA, r_valvG, r_carregar, r_habilitar, r_alarme, r_fim;
    logic               w_fim, w_limpar, w_carga, w_tick;
    logic [LARGURA-1:0] w_valor, w_restante;
    logic               w_zero, w_um, w_pausa, w_nivel_baixo, w_pedido, w_pedido_modo;

`ifdef PAUSA_EN
    assign w_pausa = pausa;
`else
    assign w_pausa = 1'b0;
`endif

    assign w_nivel_baixo = ({1'b0, nivelDagua} < N_MIN);
    assign w_pedido      = aspersao | gotejamento;
    assign w_pedido_modo = (r_modo == ASP) ? aspersao : gotejamento;

    contador_regressivo #(.LARGURA(LARGURA)) u_contador (
        .i_clock    (clock),
        .i_resetN   (resetN),
        .i_limpar   (w_limpar),
        .i_carregar (w_carga),
        .i_valor    (w_valor),
        .i_tick     (w_tick),
        .o_valor    (w_restante),
        .o_zero     (w_zero),
        .o_um       (w_um)
    );

    always_comb begin
        w_prox      = r_estado;
        w_modo_prox = r_modo;
        w_limpar    = 1'b0;
        w_carga     = 1'b0;
        w_valor     = '0;
        w_tick      = 1'b0;
        w_fim       = 1'b0;
        case (r_estado)
            CARREGA: begin
                w_carga = 1'b1;
                w_valor = (r_modo == ASP) ? T_ASP : T_GOT;
                w_prox  = IRRIGA;
            end
            IRRIGA: begin
                if (w_nivel_baixo) begin
                    w_limpar = 1'b1;
                    w_prox   = ALARME;
                end else if (!w_pedido_modo) begin
                    w_limpar = 1'b1;
                    w_prox   = OCIOSO;
                end else if (w_pausa) begin
                    w_prox = PAUSA;
                end else if (umSegundo) begin
                    w_tick = 1'b1;
                    if (w_um) begin
                        w_fim  = 1'b1;
                        w_prox = DESCANSO;
                    end
                end
            end
`ifdef PAUSA_EN
            PAUSA: begin
                if (w_nivel_baixo) begin
                    w_limpar = 1'b1;
                    w_prox   = ALARME;
                end else if (!w_pedido_modo) begin
                    w_limpar = 1'b1;
                    w_prox   = OCIOSO;
                end else if (!w_pausa) begin
                    w_prox = IRRIGA;
                end
            end
`endif
            DESCANSO: begin
                // r_fim marks the first rest cycle: the rest time is loaded after restante showed 0
                if (r_fim) begin
                    w_carga = 1'b1;
                    w_valor = T_DESC;
                end else if (w_zero) begin
                    w_prox = OCIOSO;
                end else if (umSegundo) begin
                    w_tick = 1'b1;
                    if (w_um) w_prox = OCIOSO;
                end
            end
            ALARME: begin
                if (!w_nivel_baixo && !w_pedido) w_prox = OCIOSO;
            end
            default: begin
                if (w_pedido && w_nivel_baixo) begin
                    w_prox = ALARME;
                end else if (aspersao) begin
                    w_modo_prox = ASP;
                    w_prox      = CARREGA;
                end else if (gotejamento) begin
                    w_modo_prox = GOT;
                    w_prox      = CARREGA;
                end
            end
        endcase
        if (w_prox == OCIOSO || w_prox == ALARME) w_modo_prox = NENHUM;
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_estado    <= OCIOSO;
            r_modo      <= NENHUM;
            r_valvA     <= 1'b0;
            r_valvG     <= 1'b0;
            r_carregar  <= 1'b0;
            r_habilitar <= 1'b0;
            r_alarme    <= 1'b0;
            r_fim       <= 1'b0;
        end else begin
            r_estado    <= w_prox;
            r_modo      <= w_modo_prox;
            r_valvA     <= (w_prox == IRRIGA) && (w_modo_prox == ASP);
            r_valvG     <= (w_prox == IRRIGA) && (w_modo_prox == GOT);
            r_carregar  <= (w_prox == CARREGA);
            r_habilitar <= (w_prox == IRRIGA);
            r_alarme    <= (w_prox == ALARME);
            r_fim       <= w_fim;
        end
    end

    assign valvulaAspersao    = r_valvA;
    assign valvulaGotejamento = r_valvG;
    assign carregar           = r_carregar;
    assign habilitar          = r_habilitar;
    assign restante           = w_restante;
    assign estado             = r_estado;
    assign alarme             = r_alarme;
    assign fim                = r_fim;

endmodule

// File: tb/tb_controlador_irrigacao.sv
// Bench for controlador_irrigacao: directed scenarios with literal expectations, then random stimulus
// against a cycle-level behavioural model; works with or without PAUSA_EN.
module tb_controlador_irrigacao;

    localparam int TA = 5;
    localparam int TG = 8;
    localparam int TD = 3;
    localparam int NM = 2;
    localparam int W  = 11;

    logic         clock = 1'b0;
    logic         resetN = 1'b1;
    logic         umSegundo = 1'b0;
    logic         aspersao = 1'b0;
    logic         gotejamento = 1'b0;
    logic         pausa = 1'b0;
    logic [2:0]   nivelDagua = 3'd4;
    logic         valvulaAspersao, valvulaGotejamento, carregar, habilitar, alarme, fim;
    logic [W-1:0] restante;
    logic [2:0]   estado;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    controlador_irrigacao #(
        .TEMPO_ASPERSAO_S    (TA),
        .TEMPO_GOTEJAMENTO_S (TG),
        .DESCANSO_S          (TD),
        .NIVEL_MINIMO        (NM),
        .LARGURA             (W)
    ) dut (
        .clock              (clock),
        .resetN             (resetN),
        .umSegundo          (umSegundo),
        .aspersao           (aspersao),
        .gotejamento        (gotejamento),
        .nivelDagua         (nivelDagua),
`ifdef PAUSA_EN
        .pausa              (pausa),
`endif
        .valvulaAspersao    (valvulaAspersao),
        .valvulaGotejamento (valvulaGotejamento),
        .carregar           (carregar),
        .habilitar          (habilitar),
        .restante           (restante),
        .estado             (estado),
        .alarme             (alarme),
        .fim                (fim)
    );

    task automatic chk(input string nome, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nome, act, exp, $time);
        end
    endtask

    // Behavioural model: phase code, mode (0 none, 1 sprinkler, 2 drip), seconds left, end pulse.
    int m_est = 0;
    int m_modo = 0;
    int m_rest = 0;
    bit m_fim = 1'b0;

    always @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            m_est  <= 0;
            m_modo <= 0;
            m_rest <= 0;
            m_fim  <= 1'b0;
        end else begin : passo
            int e, md, r;
            bit f, baixo, pedido;
            e = m_est;
            md = m_modo;
            r = m_rest;
            f = 1'b0;
            baixo = (int'(nivelDagua) < NM);
            pedido = (md == 1) ? aspersao : gotejamento;
            if (e == 1) begin
                r = (md == 1) ? TA : TG;
                e = 2;
            end else if (e == 2 || e == 5) begin
                if (baixo) begin
                    r = 0; e = 4; md = 0;
                end else if (!pedido) begin
                    r = 0; e = 0; md = 0;
                end else if (e == 2 && pausa) begin
                    e = 5;
                end else if (e == 5 && !pausa) begin
                    e = 2;
                end else if (e == 2 && umSegundo) begin
                    r = r - 1;
                    if (r == 0) begin
                        f = 1'b1; e = 3;
                    end
                end
            end else if (e == 3) begin
                if (m_fim) r = TD;
                else if (umSegundo) begin
                    r = r - 1;
                    if (r == 0) e = 0;
                end
            end else if (e == 4) begin
                if (!baixo && !aspersao && !gotejamento) e = 0;
            end else begin
                if ((aspersao || gotejamento) && baixo) e = 4;
                else if (aspersao) begin md = 1; e = 1; end
                else if (gotejamento) begin md = 2; e = 1; end
            end
            m_est  <= e;
            m_modo <= md;
            m_rest <= r;
            m_fim  <= f;
        end
    end

    always @(negedge clock) begin
        chk("estado", estado, m_est);
        chk("restante", restante, m_rest);
        chk("fim", fim, m_fim);
        chk("carregar", carregar, m_est == 1);
        chk("habilitar", habilitar, m_est == 2);
        chk("alarme", alarme, m_est == 4);
        chk("valvulaAspersao", valvulaAspersao, m_est == 2 && m_modo == 1);
        chk("valvulaGotejamento", valvulaGotejamento, m_est == 2 && m_modo == 2);
    end

    task automatic step(input bit t);
        umSegundo = t;
        @(posedge clock);
        #2;
        umSegundo = 1'b0;
    endtask

    initial begin
        #1 resetN = 1'b0;
        repeat (3) @(posedge clock);
        #2;
        chk("reset_estado", estado, 0);
        chk("reset_restante", restante, 0);
        chk("reset_valvula", valvulaAspersao, 0);
        resetN = 1'b1;

        // Full sprinkler cycle and rest
        aspersao = 1'b1;
        step(0);
        chk("s1_carrega", estado, 1);
        chk("s1_carregar", carregar, 1);
        step(0);
        chk("s1_restante5", restante, 5);
        chk("s1_valvA", valvulaAspersao, 1);
        chk("s1_habilitar", habilitar, 1);
        for (int i = 0; i < 4; i++) step(1);
        chk("s1_restante1", restante, 1);
        step(1);
        chk("s1_descanso", estado, 3);
        chk("s1_fim", fim, 1);
        chk("s1_restante0", restante, 0);
        aspersao = 1'b0;
        step(0);
        chk("s1_descanso3", restante, 3);
        chk("s1_fim_pulso", fim, 0);
        for (int i = 0; i < 3; i++) step(1);
        chk("s1_ocioso", estado, 0);

        // Both requests: sprinkler wins; drip drop ignored; sprinkler drop aborts
        aspersao = 1'b1;
        gotejamento = 1'b1;
        step(0);
        step(0);
        chk("s2_valvA", valvulaAspersao, 1);
        chk("s2_valvG", valvulaGotejamento, 0);
        gotejamento = 1'b0;
        step(1);
        step(1);
        chk("s2_restante3", restante, 3);
        aspersao = 1'b0;
        step(0);
        chk("s2_abort_estado", estado, 0);
        chk("s2_abort_restante", restante, 0);
        chk("s2_abort_fim", fim, 0);

        // Drip cycle, level drop on a tick
        gotejamento = 1'b1;
        step(0);
        step(0);
        chk("s3_restante8", restante, 8);
        for (int i = 0; i < 4; i++) step(1);
        nivelDagua = 3'd1;
        step(1);
        chk("s3_alarme_estado", estado, 4);
        chk("s3_alarme_restante", restante, 0);
        chk("s3_alarme", alarme, 1);
        nivelDagua = 3'd3;
        step(0);
        step(0);
        chk("s3_alarme_mantido", estado, 4);
        gotejamento = 1'b0;
        step(0);
        chk("s3_ocioso", estado, 0);

        // Request at low level goes straight to alarm
        nivelDagua = 3'd1;
        aspersao = 1'b1;
        step(0);
        chk("s4_alarme", estado, 4);
        chk("s4_valvA", valvulaAspersao, 0);
        aspersao = 1'b0;
        step(0);
        chk("s4_nivel_baixo", estado, 4);
        nivelDagua = 3'd5;
        step(0);
        chk("s4_ocioso", estado, 0);

        // Asynchronous reset mid-cycle
        aspersao = 1'b1;
        step(0);
        step(0);
        for (int i = 0; i < 3; i++) step(1);
        chk("s5_restante2", restante, 2);
        resetN = 1'b0;
        #1;
        chk("s5_reset_estado", estado, 0);
        chk("s5_reset_restante", restante, 0);
        chk("s5_reset_valvA", valvulaAspersao, 0);
        chk("s5_reset_habilitar", habilitar, 0);
        @(posedge clock);
        #2;
        resetN = 1'b1;
        step(0);
        chk("s5_carrega", estado, 1);
        aspersao = 1'b0;
        step(0);
        step(0);
        chk("s5_ocioso", estado, 0);

`ifdef PAUSA_EN
        gotejamento = 1'b1;
        step(0);
        step(0);
        step(1);
        step(1);
        chk("s6_restante6", restante, 6);
        pausa = 1'b1;
        step(0);
        chk("s6_pausa", estado, 5);
        for (int i = 0; i < 4; i++) step(1);
        chk("s6_retido", restante, 6);
        chk("s6_valvG", valvulaGotejamento, 0);
        pausa = 1'b0;
        step(0);
        chk("s6_retoma", estado, 2);
        step(1);
        chk("s6_restante5", restante, 5);
        gotejamento = 1'b0;
        step(0);
`endif

        // Random stimulus against the model
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 599) == 0) begin
                resetN = 1'b0;
                step(0);
                resetN = 1'b1;
            end
            if ($urandom_range(0, 24) == 0) aspersao = ~aspersao;
            if ($urandom_range(0, 24) == 0) gotejamento = ~gotejamento;
            if ($urandom_range(0, 39) == 0) nivelDagua = 3'($urandom_range(0, 7));
`ifdef PAUSA_EN
            if ($urandom_range(0, 14) == 0) pausa = ~pausa;
`endif
            step($urandom_range(0, 2) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
